// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_unit
//  Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO
//             registers. Signed/unsigned single-step multiply, restoring
//             divide one quotient bit per cycle, MTHI/MTLO writes, stall
//             request while busy, flush abort.
//  Options  : MDU_DIVZERO_FAST_EN - divide by zero bypasses the iterations
//             and returns lo = all ones, hi = raw dividend.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [7:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              flush,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   // ALU operation codes produced by decode (defines.vh encoding)
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
   localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] op_a;        // multiplicand, or raw dividend
   logic [DATA_W-1:0] op_b;        // multiplier, or divisor magnitude
   logic [DATA_W-1:0] quot;        // dividend shifts out as quotient shifts in
   logic [DATA_W-1:0] rem;         // partial remainder
   logic [CNT_W-1:0]  cnt;
   logic              mul_signed;
   logic              q_neg;
   logic              r_neg;
`ifdef MDU_DIVZERO_FAST_EN
   logic              dz_fast;     // FIX reached directly from a zero divisor
`endif

   // Operation decode
   logic is_mul, is_div, div_signed;
   assign is_mul     = (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
   assign is_div     = (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
   assign div_signed = (op == EXE_DIV_OP);

   // Operand magnitudes for the signed divide; unsigned passes through
   logic [DATA_W-1:0] a_abs, b_abs;
   assign a_abs = (div_signed && a[DATA_W-1]) ? -a : a;
   assign b_abs = (div_signed && b[DATA_W-1]) ? -b : b;

   // Full-width product: extend per signedness, then a plain 2W x 2W multiply
   logic [2*DATA_W-1:0] ext_a, ext_b, product;
   assign ext_a   = mul_signed ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
   assign ext_b   = mul_signed ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
   assign product = ext_a * ext_b;

   // One restoring-division step: shift in next dividend bit, trial subtract
   logic [DATA_W:0]   shifted, diff;
   logic              q_bit;
   logic [DATA_W-1:0] rem_next;
   assign shifted  = {rem, quot[DATA_W-1]};
   assign diff     = shifted - {1'b0, op_b};
   assign q_bit    = ~diff[DATA_W];
   assign rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

   // Stall covers the requesting cycle as well as every busy cycle
   assign stall = (state != S_IDLE) | (start & (is_mul | is_div) & ~flush);

   // Control FSM, operand latches, division datapath and HI/LO registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         op_a       <= '0;
         op_b       <= '0;
         quot       <= '0;
         rem        <= '0;
         cnt        <= '0;
         mul_signed <= 1'b0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
`ifdef MDU_DIVZERO_FAST_EN
         dz_fast    <= 1'b0;
`endif
         done       <= 1'b0;
         hi         <= '0;
         lo         <= '0;
      end else begin
         done <= 1'b0;
         if (state != S_IDLE && flush) begin
            // Abort: HI/LO untouched, no completion pulse
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !flush) begin
                     if (op == EXE_MTHI_OP) hi <= a;
                     if (op == EXE_MTLO_OP) lo <= a;
                     if (is_mul) begin
                        op_a       <= a;
                        op_b       <= b;
                        mul_signed <= (op == EXE_MULT_OP);
                        state      <= S_MUL;
                     end
                     if (is_div) begin
                        op_a  <= a;
                        op_b  <= b_abs;
                        quot  <= a_abs;
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= div_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                        r_neg <= div_signed & a[DATA_W-1];
                        state <= S_DIV;
`ifdef MDU_DIVZERO_FAST_EN
                        dz_fast <= (b == '0);
                        if (b == '0) state <= S_FIX;
`endif
                     end
                  end
               end
               S_MUL: begin
                  {hi, lo} <= product;
                  done     <= 1'b1;
                  state    <= S_IDLE;
               end
               S_DIV: begin
                  quot <= {quot[DATA_W-2:0], q_bit};
                  rem  <= rem_next;
                  cnt  <= cnt + CNT_ONE;
                  if (cnt == CNT_LAST) state <= S_FIX;
               end
               S_FIX: begin
`ifdef MDU_DIVZERO_FAST_EN
                  if (dz_fast) begin
                     lo <= '1;
                     hi <= op_a;
                  end else begin
                     lo <= q_neg ? -quot : quot;
                     hi <= r_neg ? -rem  : rem;
                  end
`else
                  lo <= q_neg ? -quot : quot;
                  hi <= r_neg ? -rem  : rem;
`endif
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_unit
//  Purpose  : Table-driven self-checking bench for mdu_unit (DATA_W = 32)
//             plus directed reset, flush and MTHI/MTLO sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

   localparam int DATA_W = 32;

   localparam logic [7:0] OP_MULT  = 8'b0001_1000;
   localparam logic [7:0] OP_MULTU = 8'b0001_1001;
   localparam logic [7:0] OP_DIV   = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
   localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
   localparam logic [7:0] OP_MTLO  = 8'b0001_0011;

`ifdef MDU_DIVZERO_FAST_EN
   localparam int DZ_LAT = 2;
`else
   localparam int DZ_LAT = DATA_W + 2;
`endif

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        op = 8'h00;
   logic [DATA_W-1:0] a = '0;
   logic [DATA_W-1:0] b = '0;
   logic              flush = 1'b0;
   logic              stall;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   int errors = 0;
   int checks = 0;

   mdu_unit #(.DATA_W(DATA_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .stall  (stall),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          lat;     // cycles from accept to done (also stall length)
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Enter a new cycle: inputs change 1 time unit after the rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue a mult/div in cycle T; return cycles until done and stall-high cycles
   task automatic run_op(input logic [7:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int lat, output int stall_cnt);
      next_cycle();
      start = 1'b1; op = o; a = va; b = vb;
      #1;
      stall_cnt = stall ? 1 : 0;
      lat = 0;
      do begin
         next_cycle();
         start = 1'b0;
         #1;
         lat++;
         if (stall) stall_cnt++;
      end while (!done && lat < 100);
      if (!done) begin
         errors++;
         $display("FAIL timeout op=0x%02h: no done within %0d cycles", o, lat);
      end
   endtask

   // MTHI/MTLO issue; value checked on the following cycle by the caller
   task automatic move_to(input logic [7:0] o, input logic [31:0] v, input logic fl);
      next_cycle();
      start = 1'b1; op = o; a = v; flush = fl;
      #1;
      check("mt_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      start = 1'b0; flush = 1'b0;
      #1;
   endtask

   initial begin
      int lat, scnt, dcnt;

      vecs[0] = '{"mult_neg3x5",   OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 2};
      vecs[1] = '{"multu_max_x2",  OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 2};
      vecs[2] = '{"mult_7xneg6",   OP_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 2};
      vecs[3] = '{"multu_2p16sq",  OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 2};
      vecs[4] = '{"div_neg7_2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DATA_W + 2};
      vecs[5] = '{"divu_100_7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DATA_W + 2};
      vecs[6] = '{"div_7_neg2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DATA_W + 2};
      vecs[7] = '{"div_ovf",       OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DATA_W + 2};
      vecs[8] = '{"divu_by_zero",  OP_DIVU,  32'h00000055, 32'd0,        32'h00000055, 32'hFFFFFFFF, DZ_LAT};

      // Reset state
      repeat (2) next_cycle();
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_stall_done", {30'd0, stall, done}, 32'd0);
      resetn = 1'b1;

      // Table of multiply/divide vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, scnt);
         check({vecs[i].name, "_lat"},   lat,  vecs[i].lat);
         check({vecs[i].name, "_stall"}, scnt, vecs[i].lat);
         check({vecs[i].name, "_hi"},    hi,   vecs[i].exp_hi);
         check({vecs[i].name, "_lo"},    lo,   vecs[i].exp_lo);
      end

      // Asynchronous reset in T+5 of a DIV abandons it and clears HI/LO
      next_cycle();
      start = 1'b1; op = OP_DIV; a = 32'hFFFFFFF9; b = 32'd2;
      next_cycle();
      start = 1'b0;
      repeat (4) next_cycle();
      resetn = 1'b0;
      #1;
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      check("midrst_stall_done", {30'd0, stall, done}, 32'd0);
      next_cycle();
      resetn = 1'b1;
      move_to(OP_MTLO, 32'h12345678, 1'b0);
      check("mtlo_lo", lo, 32'h12345678);
      check("mtlo_hi", hi, 32'd0);
      check("post_rst_idle", {31'd0, stall}, 32'd0);

      // Known HI/LO before the flush sequence
      move_to(OP_MTHI, 32'hAAAA5555, 1'b0);
      check("mthi_hi", hi, 32'hAAAA5555);

      // Flush in T+10 of a DIV: abort, no done, HI/LO preserved
      next_cycle();
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      next_cycle();
      start = 1'b0;
      repeat (9) next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      dcnt = done ? 1 : 0;
      next_cycle();
      #1;
      check("flush_stall_T12", {31'd0, stall}, 32'd0);
      for (int k = 0; k < 40; k++) begin
         if (done) dcnt++;
         next_cycle();
      end
      check("flush_no_done", dcnt, 0);
      check("flush_hi", hi, 32'hAAAA5555);
      check("flush_lo", lo, 32'h12345678);

      // start + flush with MTHI: suppressed
      move_to(OP_MTHI, 32'hDEADBEEF, 1'b1);
      check("mthi_flushed", hi, 32'hAAAA5555);

      // Unrecognised op is ignored
      next_cycle();
      start = 1'b1; op = 8'h20; a = 32'h01010101; b = 32'd3;
      #1;
      check("badop_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      start = 1'b0;
      #1;
      check("badop_lo", lo, 32'h12345678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core's execute stage. It consumes the 8-bit ALU operation code produced by the decode stage for the mult/div and HI/LO-move operations, and runs signed and unsigned multiply and divide. It raises a stall request toward the hazard unit while busy and exposes HI/LO to the MFHI/MFLO result path. Data width is a parameter, generalising the fixed 32-bit datapath.

## Interface
- `DATA_W`, 32: operand and HI/LO width; must be even and ≥ 8.
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: operation request, qualified by `op`.
- `op` in 8: ALU operation code; acts only on `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP` from defines.vh; all other codes are ignored.
- `a` in DATA_W: rs operand (dividend / multiplicand / MTHI-MTLO source).
- `b` in DATA_W: rt operand (divisor / multiplier).
- `flush` in 1: exception/flush from the pipeline control; aborts the current operation.
- `stall` out 1: stall request to the hazard unit.
- `done` out 1: one-cycle pulse when HI/LO are written by a mult or div.
- `hi` out DATA_W: HI register.
- `lo` out DATA_W: LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accept: `start`=1 in IDLE with `flush`=0 and a recognised `op`. Requests in any other state are ignored; the hazard unit holds the instruction in execute until `stall` drops.
- MTHI/MTLO: write `hi`/`lo` = `a` at the accept edge. No state change, no `stall`, no `done`.
- MULT/MULTU:
  - IDLE→MUL at the accept edge; operands are latched then.
  - MUL: the full 2·DATA_W product, signed or unsigned, is written to {hi,lo} at the next edge.
  - MUL→IDLE.
- DIV/DIVU:
  - IDLE→DIV at the accept edge; the magnitudes of `a` and `b` are latched (signed variant), plus the quotient sign (a^b MSBs) and the remainder sign (a MSB).
  - DIV runs restoring division, one quotient bit per cycle. The iteration counter counts 0..DATA_W-1.
  - DIV→FIX after the last bit.
  - FIX applies sign correction, writes lo=quotient and hi=remainder, then goes to IDLE.
- Signed overflow case (most-negative / -1): quotient = most-negative, remainder = 0; no trap.
- Divide by zero: behaviour is governed by the macro under Configuration.
- `stall` = (state≠IDLE) | (`start` & `op`∈{mult,multu,div,divu} & ¬`flush`), so the requesting instruction stalls in its own cycle.
- `done` is high in the cycle after the HI/LO write edge, i.e. registered.
- `flush`:
  - In any non-IDLE state: state→IDLE at the next edge; HI/LO are unchanged, no `done`, `stall` falls the cycle after.
  - `flush` and `start` together: `flush` wins, nothing is accepted; MTHI/MTLO are also suppressed.

## Timing
- Reset values: `hi`=0, `lo`=0, `stall`=0 once reset is applied, `done`=0, state IDLE, counter 0.
- Reset asserted mid-operation: the operation is abandoned immediately.
- Accept in cycle T:
  - MTHI/MTLO: visible in T+1.
  - MULT: HI/LO written at the end of T+1; `done` and new HI/LO visible in T+2. `stall` is high in T and T+1.
  - DIV: iterations in T+1..T+DATA_W, FIX in T+DATA_W+1; `done` and new values visible in T+DATA_W+2. `stall` is high T..T+DATA_W+1 (DATA_W+2 cycles).
- Back-to-back: a new `start` may be accepted in the same cycle `done` is high.

## Configuration
- `MDU_DIVZERO_FAST_EN`:
  - Defined: a divide with `b`=0 skips DIV. IDLE→FIX at the accept edge, giving lo = all ones and hi = `a` (raw operand, no sign fix), with `done` in T+2.
  - Undefined: divide by zero runs the full DATA_W iterations, whose natural result is quotient all ones and remainder = |a|, then sign-corrected as for any divide, with standard latency.

## Test plan
- Reset with `resetn`=0 mid-DIV (T+5) → `hi`=`lo`=0, `stall`=0, state IDLE; a subsequent MTLO 0x12345678 → `lo`=0x12345678 in the next cycle.
- MULT a=0xFFFFFFFD (-3), b=5 → `done` in T+2, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → `stall` high for 34 cycles, `done` in T+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x55, b=0:
  - With macro: `done` in T+2, lo=0xFFFFFFFF, hi=0x55.
  - Without macro: `done` in T+34, same values.
- `flush` asserted in T+10 of a DIV → `stall` low from T+12, HI/LO keep their prior values, no `done`. `start`+`flush` in the same cycle with MTHI → `hi` unchanged.
